// File: rtl/guitar_input_conditioner_pkg.sv
// Shared constants and sizing helper for the guitar input conditioner.
package guitar_input_pkg;

    localparam int NUM_FRETS = 4;
    localparam int NUM_LANES = 4;

    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 500000;
    localparam int DEF_GAMECLK_DIV     = 833333;

    // Bits needed to hold the values 0..n-1 (at least one bit).
    function automatic int cnt_width(input int n);
        int w;
        w = 1;
        while ((64'(1) << w) < 64'(n)) w++;
        return w;
    endfunction

endpackage

// File: rtl/guitar_input_conditioner_if.sv
// Raw controller/sensor pins in, conditioned processor-domain levels out.
interface guitar_input_conditioner_if;
    import guitar_input_pkg::*;

    logic [NUM_FRETS-1:0] btn_raw;
    logic                 strum_raw;
    logic [NUM_LANES-1:0] isect_raw;
    logic [NUM_FRETS-1:0] buttons;
    logic [NUM_LANES-1:0] intersections;
    logic                 strum;
    logic                 gameclk;

    modport master (
        output btn_raw, strum_raw, isect_raw,
        input  buttons, intersections, strum, gameclk
    );

    modport slave (
        input  btn_raw, strum_raw, isect_raw,
        output buttons, intersections, strum, gameclk
    );

endinterface

// File: rtl/guitar_input_conditioner_debounce.sv
// One raw input: SYNC_STAGES-deep synchronizer followed by a consecutive-cycle debounce counter.
module debounce_channel
    import guitar_input_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic stable,
    output logic rise
);

    localparam int            CW   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt;
    logic                   synced;
    logic                   accept;

    assign synced = sync_q[SYNC_STAGES-1];
    assign accept = (synced != stable) && (cnt == LAST);

    // Strobes on the cycle a new high level is accepted, so the consumer's
    // register lines up with the stable edge rather than trailing it.
    assign rise = accept && synced;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= '0;
            cnt    <= '0;
            stable <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
            if (synced == stable) begin
                cnt <= '0;
            end else if (accept) begin
                stable <= synced;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/guitar_input_conditioner.sv
// Guitar front end: debounced frets/strum, synchronized sensors, game timebase.
// Define STRUM_HOLD_EN to make strum a level held until the next game tick.
module guitar_input_conditioner
    import guitar_input_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int GAMECLK_DIV     = DEF_GAMECLK_DIV
) (
    input logic                        clock,
    input logic                        reset,
    guitar_input_conditioner_if.slave  io
);

    localparam int            GW      = cnt_width(GAMECLK_DIV);
    localparam logic [GW-1:0] GC_LAST = GW'(GAMECLK_DIV - 1);
    localparam logic [GW-1:0] GC_HALF = GW'(GAMECLK_DIV / 2);

    logic [NUM_FRETS-1:0]                  btn_stable;
    logic [NUM_FRETS-1:0]                  btn_rise_unused;
    logic                                  strum_rise;
    logic                                  strum_level_unused;
    logic [SYNC_STAGES-1:0][NUM_LANES-1:0] isect_q;
    logic [GW-1:0]                         gc_cnt;
    logic                                  gameclk_q;
    logic                                  strum_q;
    logic                                  gc_wrap;

    for (genvar i = 0; i < NUM_FRETS; i++) begin : g_btn
        debounce_channel #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clock (clock),
            .reset (reset),
            .raw   (io.btn_raw[i]),
            .stable(btn_stable[i]),
            .rise  (btn_rise_unused[i])
        );
    end

    debounce_channel #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_strum (
        .clock (clock),
        .reset (reset),
        .raw   (io.strum_raw),
        .stable(strum_level_unused),
        .rise  (strum_rise)
    );

    // The cycle the counter sits at 0 is the one whose edge raises gameclk.
    assign gc_wrap = (gc_cnt == '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            isect_q   <= '0;
            gc_cnt    <= '0;
            gameclk_q <= 1'b0;
            strum_q   <= 1'b0;
        end else begin
            isect_q   <= {isect_q[SYNC_STAGES-2:0], io.isect_raw};
            gc_cnt    <= (gc_cnt == GC_LAST) ? '0 : gc_cnt + 1'b1;
            gameclk_q <= (gc_cnt < GC_HALF);
`ifdef STRUM_HOLD_EN
            // Set beats clear when both land on the same edge.
            strum_q   <= strum_rise | (strum_q & ~gc_wrap);
`else
            strum_q   <= strum_rise;
`endif
        end
    end

`ifndef STRUM_HOLD_EN
    logic gc_wrap_unused;
    assign gc_wrap_unused = gc_wrap;
`endif

    assign io.buttons       = btn_stable;
    assign io.intersections = isect_q[SYNC_STAGES-1];
    assign io.strum         = strum_q;
    assign io.gameclk       = gameclk_q;

endmodule
